hist_bin_streamer: RTL and testbench
====================================

# hist_bin_streamer

Histogram bin accumulator and AXI-Stream transmitter that produces the write-word stream consumed by the AXI-Stream RAM slave. It counts per-bin events from the datapath. On a flush request it snapshots all bins and streams one 32-bit word per bin, formatted as {addr[7:0], count[23:0]}, so that the RAM stores each bin count at its 4-byte-aligned address in the bin-count region (0x00–0x1F).

## Interface
Parameters:
- NUM_BINS, 8: number of bins. Legal values are 2..8.
- BASE_ADDR, 8'h00: RAM byte address of bin 0. Bin i is written to address BASE_ADDR + 4*i. BASE_ADDR + 4*(NUM_BINS-1) must be < 8'h20.

Ports (one clock; reset is asynchronous and active-high):
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous active-high reset.
- bin_valid  in  1  increment request for bin_idx in this cycle.
- bin_idx  in  3  bin to increment. Values >= NUM_BINS are ignored.
- flush  in  1  single-cycle request to snapshot and stream all bins.
- busy  out  1  high while a flush stream is in progress.
- sat  out  1  sticky flag: some live counter hit saturation.
- m_axis_tdata  out  32  {address[7:0], count[23:0]}.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the word for bin NUM_BINS-1.

## Operation
- Live counters: NUM_BINS × 24 bits, unsigned.
  - bin_valid with an in-range bin_idx increments that counter by 1.
  - A counter at 24'hFFFFFF holds its value and sets sat.
  - sat clears only on reset.
- Snapshot: NUM_BINS × 24-bit shadow registers, loaded only when a flush is accepted.
- State machine:
  - IDLE, flush=1: load shadows from the live counters and clear all live counters, both at the same edge. Set index=0, busy=1, and go to SEND.
  - SEND: drive tvalid=1 with tdata = {BASE_ADDR + 4*index, shadow[index]} and tlast = (index == NUM_BINS-1).
    - On handshake (tvalid && tready) with index < NUM_BINS-1: index increments.
    - On handshake with index == NUM_BINS-1: go to IDLE and drop busy.
  - flush is ignored while in SEND; it is not queued.
- Address arithmetic is 8-bit. The parameter constraint guarantees no wrap.
- Simultaneous bin_valid and accepted flush: the increment is excluded from the snapshot. The live counter for that bin becomes 1 after the clear.
- Increments during SEND update the live counters normally. They never affect the shadows or the words already in the stream.
- areset mid-stream: the stream aborts immediately with no tlast.
  - All counters, shadows, index and sat clear.
  - The FSM returns to IDLE.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=32'h0, busy=0, sat=0, state=IDLE. All counters and shadows are 0.
- All outputs are registered.
- Flush sampled high at edge N (in IDLE): busy and tvalid are high after edge N, with the word for bin 0 presented.
- AXI-Stream rules:
  - tdata and tlast stay stable while tvalid && !tready.
  - tvalid never drops before the handshake.
  - tvalid does not depend combinationally on tready.
- Throughput is 1 word per cycle when tready is held high. A full flush then takes NUM_BINS cycles from the first tvalid.
- Handshake of the last word at edge M: tvalid, tlast and busy are 0 after edge M. A flush sampled at edge M+1 is accepted.
- Live-counter increment latency: 1 cycle. A bin_valid sampled at edge N is visible to a flush sampled at edge N+1.

## Test plan
- Reset, then 3× bin 0, 5× bin 2, 1× bin 7; flush with tready=1 -> 8 consecutive words: 0x00000003, 0x04000000, 0x08000005, …, 0x1C000001 with tlast on the last. busy is high for 8 cycles. Live counters read 0 on a second flush.
- Flush with tready alternating 1/0 (RAM-like), then held low 5 cycles mid-stream -> tdata and tlast stay stable while stalled; no word is dropped or duplicated; tlast appears only on 0x1C word.
- bin_valid for bin 2 in the same cycle as flush, with bin 2 at 4 -> stream carries 0x08000004; the next flush carries 0x08000001.
- A second flush pulse during SEND, plus increments of bin 1 during SEND -> the pulse is ignored with one stream only. The following flush shows the bin 1 increments.
- Preload bin 5 to 24'hFFFFFE, then 3 increments -> sat=1 and the flushed word is 0x14FFFFFF. bin_idx values ≥ NUM_BINS leave all counts unchanged.
- areset asserted after the 3rd handshake -> tvalid drops immediately and all outputs return to reset values. The next flush streams all-zero counts.

Source files
------------

// File: rtl/hist_bin_streamer.sv
// Histogram bin accumulator: counts per-bin events and, on flush, streams one
// {addr[7:0], count[23:0]} AXI-Stream word per bin from a snapshot.
module hist_bin_streamer #(
    parameter int unsigned NUM_BINS  = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h00
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        bin_valid,
    input  logic [2:0]  bin_idx,
    input  logic        flush,
    output logic        busy,
    output logic        sat,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_BINS - 1);

    state_t                      state, state_nxt;
    logic [2:0]                  idx, idx_nxt;
    logic [NUM_BINS-1:0][23:0]   live_cnt, live_nxt, shadow;
    logic                        flush_acc, sat_set;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        flush_acc = 1'b0;
        case (state)
            IDLE: if (flush) begin
                flush_acc = 1'b1;
                idx_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: if (m_axis_tready) begin
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An increment coinciding with an accepted flush lands after the clear.
    always_comb begin
        live_nxt = flush_acc ? '0 : live_cnt;
        sat_set  = 1'b0;
        for (int unsigned i = 0; i < NUM_BINS; i++) begin
            if (live_cnt[i] == '1) sat_set = 1'b1;
            if (bin_valid && bin_idx == 3'(i)) begin
                if (flush_acc)
                    live_nxt[i] = 24'd1;
                else if (live_cnt[i] != '1)
                    live_nxt[i] = live_cnt[i] + 24'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            idx      <= '0;
            live_cnt <= '0;
            shadow   <= '0;
            sat      <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            live_cnt <= live_nxt;
            sat      <= sat | sat_set;
            if (flush_acc) shadow <= live_cnt;
        end
    end

    assign busy          = (state == SEND);
    assign m_axis_tvalid = busy;
    assign m_axis_tlast  = busy && (idx == LAST_IDX);
    assign m_axis_tdata  = busy ? {BASE_ADDR + {3'b000, idx, 2'b00}, shadow[idx]} : '0;

endmodule

// File: tb/tb_hist_bin_streamer.sv
// Scoreboard bench for hist_bin_streamer: expected words are queued on flush
// and popped as the DUT hands them off.
module tb_hist_bin_streamer;

    logic        aclk = 1'b0;
    logic        areset, bin_valid, flush, tready;
    logic [2:0]  bin_idx;
    logic        busy, sat, tvalid, tlast;
    logic [31:0] tdata;

    logic        tready6 = 1'b1;
    logic        busy6, sat6, tvalid6, tlast6;
    logic [31:0] tdata6;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          hs_count = 0;
    logic [23:0] mdl [8];
    logic [32:0] exp_q [$];
    logic [32:0] got6 [$];
    logic        stall_pend = 1'b0;
    logic [32:0] stall_word;

    always #5 aclk = ~aclk;

    hist_bin_streamer #(.NUM_BINS(8), .BASE_ADDR(8'h00)) dut (
        .aclk(aclk), .areset(areset), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .flush(flush), .busy(busy), .sat(sat), .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    hist_bin_streamer #(.NUM_BINS(6), .BASE_ADDR(8'h04)) dut6 (
        .aclk(aclk), .areset(areset), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .flush(flush), .busy(busy6), .sat(sat6), .m_axis_tdata(tdata6),
        .m_axis_tvalid(tvalid6), .m_axis_tready(tready6), .m_axis_tlast(tlast6)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic inc(input logic [2:0] b);
        bin_valid = 1'b1;
        bin_idx   = b;
        tick();
        bin_valid = 1'b0;
        if (mdl[b] != 24'hFFFFFF) mdl[b] = mdl[b] + 24'd1;
    endtask

    task automatic do_flush(input bit with_inc, input logic [2:0] b);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 7), 8'(4 * i), mdl[i]});
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        if (with_inc) mdl[b] = 24'd1;
        flush     = 1'b1;
        bin_valid = with_inc;
        bin_idx   = b;
        tick();
        flush     = 1'b0;
        bin_valid = 1'b0;
    endtask

    // pat 0: tready high; pat 1: alternating with a 5-cycle low window.
    task automatic wait_stream(input int pat, input bit chk_busy);
        int c  = 0;
        int bc = 0;
        while ((busy || exp_q.size() != 0) && c < 300) begin
            tready = (pat == 0) ? 1'b1 : ((c >= 6 && c < 11) ? 1'b0 : (c % 2 == 0));
            if (busy) bc++;
            tick();
            c++;
        end
        tready = 1'b1;
        check_eq("stream_timeout", (c >= 300), 0);
        if (chk_busy) check_eq("busy_cycles", bc, 8);
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            if (stall_pend) begin
                check_eq("stall_tvalid", tvalid, 1);
                check_eq("stall_word", {tlast, tdata}, stall_word);
            end
            stall_pend = tvalid && !tready;
            stall_word = {tlast, tdata};
            if (tvalid && tready) begin
                hs_count++;
                if (exp_q.size() == 0)
                    check_eq("unexpected_word", exp_q.size(), 1);
                else
                    check_eq("word", {tlast, tdata}, exp_q.pop_front());
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    always @(negedge aclk)
        if (!areset && tvalid6) got6.push_back({tlast6, tdata6});

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][23:0] pre;
        int c;
        int hs0;
        areset = 1'b1; bin_valid = 1'b0; bin_idx = '0; flush = 1'b0; tready = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        repeat (3) tick();
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_tlast", tlast, 0);
        check_eq("rst_tdata", tdata, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sat", sat, 0);
        areset = 1'b0;
        tick();

        // Basic counts, full-rate stream, then a flush of the cleared counters
        repeat (3) inc(3'd0);
        repeat (5) inc(3'd2);
        inc(3'd7);
        do_flush(0, 3'd0);
        wait_stream(0, 1);
        do_flush(0, 3'd0);
        wait_stream(0, 0);

        // Backpressure: alternating ready plus a long stall
        repeat (2) inc(3'd3);
        inc(3'd6);
        inc(3'd1);
        do_flush(0, 3'd0);
        wait_stream(1, 0);

        // Increment coinciding with flush
        repeat (4) inc(3'd2);
        do_flush(1, 3'd2);
        wait_stream(0, 0);
        do_flush(0, 3'd0);
        wait_stream(0, 0);

        // Flush during SEND is ignored; increments during SEND are kept live
        inc(3'd4);
        tready = 1'b0;
        do_flush(0, 3'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) inc(3'd1);
        wait_stream(0, 0);
        tick();
        check_eq("no_second_stream", busy, 0);
        do_flush(0, 3'd0);
        wait_stream(0, 0);

        // Saturation
        for (int i = 0; i < 8; i++) pre[i] = mdl[i];
        pre[5] = 24'hFFFFFE;
        force dut.live_nxt = pre;
        tick();
        release dut.live_nxt;
        mdl[5] = 24'hFFFFFE;
        tick();
        check_eq("sat_before", sat, 0);
        repeat (3) inc(3'd5);
        tick();
        check_eq("sat_after", sat, 1);
        do_flush(0, 3'd0);
        wait_stream(0, 0);
        check_eq("sat_sticky", sat, 1);

        // Reset mid-stream after the third handshake
        repeat (2) inc(3'd3);
        tready = 1'b1;
        hs0 = hs_count;
        do_flush(0, 3'd0);
        c = 0;
        while (hs_count - hs0 < 3 && c < 50) begin
            tick();
            c++;
        end
        check_eq("hs_timeout", (c >= 50), 0);
        areset = 1'b1;
        #1;
        check_eq("abort_tvalid", tvalid, 0);
        check_eq("abort_tlast", tlast, 0);
        check_eq("abort_tdata", tdata, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_sat", sat, 0);
        tick();
        areset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        tick();
        do_flush(0, 3'd0);
        wait_stream(0, 0);

        // Out-of-range bin indices on the 6-bin instance
        got6.delete();
        inc(3'd1);
        inc(3'd6);
        repeat (2) inc(3'd7);
        do_flush(0, 3'd0);
        wait_stream(0, 0);
        check_eq("dut6_count", got6.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < got6.size())
                check_eq("dut6_word", got6[i], {(i == 5), 8'(8'h04 + 4 * i), (i == 1) ? 24'd1 : 24'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
